csa_stream_accumulator: RTL and testbench



---
 rtl/csa_stream_acc_pkg.sv | 15 +
 rtl/csa_row.sv | 21 ++
 rtl/csa_stream_accumulator.sv | 99 +++++++++
 tb/tb_csa_stream_accumulator.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/csa_stream_acc_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
package csa_stream_acc_pkg;

  typedef enum logic [1:0] {
    StAccum,
    StResolve,
    StHold
  } acc_state_e;

  // Result width: enough headroom for num_ops full-scale w-bit operands.
  function automatic int unsigned calc_out_w(input int unsigned w, input int unsigned num_ops);
    return w + $clog2(num_ops);
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 compressors: bitwise sum and majority carry shifted up one place.
module csa_row #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [Width-1:0] c_i,
  output logic [Width-1:0] sum_o,
  output logic [Width-1:0] carry_o
);

  logic [Width-1:0] maj;

  always_comb begin
    sum_o   = a_i ^ b_i ^ c_i;
    maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    // Top majority bit is always zero while the running total fits in Width bits.
    carry_o = maj << 1;
  end

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streams NUM_OPS operands into redundant sum/carry registers, then resolves and presents the total.
// Optional macro CSA_STREAM_ACC_LAST_EN adds in_last to terminate a sum early.
module csa_stream_accumulator
  import csa_stream_acc_pkg::*;
#(
  parameter  int unsigned W       = 4,
  parameter  int unsigned NUM_OPS = 10,
  localparam int unsigned OUT_W   = calc_out_w(W, NUM_OPS),
  localparam int unsigned CNT_W   = $clog2(NUM_OPS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
`ifdef CSA_STREAM_ACC_LAST_EN
  input  logic             in_last,
`endif
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
);

  acc_state_e       state_q;
  logic [OUT_W-1:0] sum_q;
  logic [OUT_W-1:0] carry_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] op_count_q;

  logic [OUT_W-1:0] x;
  logic [OUT_W-1:0] row_sum;
  logic [OUT_W-1:0] row_carry;
  logic             accept;
  logic             end_of_sum;

  assign x         = OUT_W'(in_data);
  assign in_ready  = (state_q == StAccum);
  assign accept    = in_valid && in_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign op_count  = op_count_q;

`ifdef CSA_STREAM_ACC_LAST_EN
  assign end_of_sum = (op_count_q == CNT_W'(NUM_OPS - 1)) || in_last;
`else
  assign end_of_sum = (op_count_q == CNT_W'(NUM_OPS - 1));
`endif

  csa_row #(
    .Width(OUT_W)
  ) u_row (
    .a_i    (sum_q),
    .b_i    (carry_q),
    .c_i    (x),
    .sum_o  (row_sum),
    .carry_o(row_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StAccum;
      sum_q       <= '0;
      carry_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (accept) begin
            sum_q      <= row_sum;
            carry_q    <= row_carry;
            op_count_q <= op_count_q + 1'b1;
            if (end_of_sum) state_q <= StResolve;
          end
        end
        StResolve: begin
          out_data_q  <= sum_q + carry_q;
          out_valid_q <= 1'b1;
          state_q     <= StHold;
        end
        StHold: begin
          // op_count keeps the finished sum's count visible until the result is taken.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= '0;
            op_count_q  <= '0;
            state_q     <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Scoreboard bench for csa_stream_accumulator; exercises CSA_STREAM_ACC_LAST_EN when defined.
module tb_csa_stream_accumulator;

  localparam int unsigned W       = 4;
  localparam int unsigned NUM_OPS = 10;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned CNT_W   = 4;
`ifdef CSA_STREAM_ACC_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] op_count;

  typedef struct packed {
    logic [OUT_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned model_sum = 0;
  int unsigned model_cnt = 0;
  logic        rand_rdy = 1'b0;

  csa_stream_accumulator #(
    .W      (W),
    .NUM_OPS(NUM_OPS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
`ifdef CSA_STREAM_ACC_LAST_EN
    .in_last  (in_last),
`endif
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Results are compared on the falling edge, including every stalled HOLD cycle.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      check_eq("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb[0];
        check_eq("out_data", out_data, mon_e.sum);
        check_eq("hold_op_count", op_count, mon_e.cnt);
        check_eq("hold_in_ready", in_ready, 0);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_op(input logic [W-1:0] d, input logic last);
    int unsigned waited = 0;
    exp_t e;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_eq("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    model_sum += d;
    model_cnt++;
    if (model_cnt == NUM_OPS || (last && LastEn)) begin
      e.sum = OUT_W'(model_sum);
      e.cnt = CNT_W'(model_cnt);
      sb.push_back(e);
      model_sum = 0;
      model_cnt = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    model_sum = 0;
    model_cnt = 0;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_op_count", op_count, 0);
    check_eq("rst_out_data", out_data, 0);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((sb.size() != 0 || out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    do_reset();

    // 1..10 back-to-back, latency and final count.
    for (int i = 1; i <= 10; i++) send_op(W'(i), 1'b0);
    check_eq("lat_in_ready", in_ready, 0);
    check_eq("lat_valid_early", out_valid, 0);
    check_eq("lat_op_count", op_count, 10);
    @(posedge clk);
    #1;
    check_eq("lat_valid", out_valid, 1);
    check_eq("sum_55", out_data, 55);
    drain("drain_seq");

    // Full-scale operands: no truncation.
    for (int i = 0; i < 10; i++) send_op(4'hF, 1'b0);
    drain("drain_max");

    // Gapped input, stalled consumer, junk presented while in HOLD.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_op(4'd3, 1'b0);
      if (i < 9) idle(1);
    end
    begin
      int k = 0;
      while (!out_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      check_eq("stall_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    in_data  = 4'd9;
    in_valid = 1'b1;
    idle(5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(1);
    check_eq("post_hold_in_ready", in_ready, 1);
    check_eq("post_hold_op_count", op_count, 0);
    drain("drain_stall");

    // Mid-sum reset discards the partial total.
    for (int i = 0; i < 4; i++) send_op(4'd7, 1'b0);
    check_eq("mid_op_count", op_count, 4);
    do_reset();
    for (int i = 0; i < 10; i++) send_op(4'd2, 1'b0);
    drain("drain_reset");

    // Random data, random gaps, random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_op(W'($urandom_range(0, 15)), 1'b0);
      idle($urandom_range(0, 2));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain("drain_rand");

    if (LastEn) begin
      send_op(4'd5, 1'b0);
      send_op(4'd6, 1'b0);
      send_op(4'd7, 1'b1);
      drain("drain_last");
      for (int i = 0; i < 10; i++) send_op(4'd1, 1'b0);
      drain("drain_after_last");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
